// File: rtl/i2c_write_reg.sv
// Initiator-side I2C register writer: buffers up to DEPTH bytes, then issues one
// start/write-multiple/stop command and streams reg_address plus the buffered bytes.
module i2c_write_reg #(
  parameter int DEPTH      = 16,
  parameter int TIMEOUT_MS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] dev_address,
  input  logic [7:0] reg_address,
  input  logic [3:0] byte_width,
  input  logic       start,
  input  logic [7:0] load_data,
  input  logic       load_en,
  output logic       load_full,
  output logic [4:0] load_count,
  output logic       busy,
  output logic       done,
  output logic       message_failure,
  input  logic       timer_exp,
  output logic       timer_start,
  output logic       timer_reset,
  output logic [3:0] timer_param,
  input  logic       i2c_cmd_ready,
  input  logic       i2c_bus_busy,
  input  logic       i2c_bus_control,
  input  logic       i2c_bus_active,
  input  logic       i2c_missed_ack,
  output logic [6:0] i2c_dev_address,
  output logic       i2c_cmd_start,
  output logic       i2c_cmd_read,
  output logic       i2c_cmd_write_multiple,
  output logic       i2c_cmd_stop,
  output logic       i2c_cmd_valid,
  output logic [7:0] i2c_data_out,
  output logic       i2c_data_out_valid,
  output logic       i2c_data_out_last,
  input  logic       i2c_data_out_ready
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_BUS, S_CMD, S_REG, S_DATA, S_FREE} state_t;
  state_t state, state_d;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic [6:0]    dev_q;
  logic [7:0]    reg_q;
  logic [3:0]    width_q, remain;
  logic          fail_d, done_d, tstart_d, push, pop, flush;

  assign push      = load_en && !load_full && (state == S_IDLE) && !start;
  assign pop       = (state == S_DATA) && i2c_data_out_ready;
  assign flush     = fail_d || done_d;
  assign load_full = (count == (AW+1)'(DEPTH));
  assign load_count = 5'(count);
  // Every transition out of a state lands in a timed stage unless it returns to idle.
  assign tstart_d  = (state_d != state) && (state_d != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= load_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dev_q   <= '0;
      reg_q   <= '0;
      width_q <= '0;
      remain  <= '0;
    end else if ((state == S_IDLE) && start) begin
      dev_q   <= dev_address;
      reg_q   <= reg_address;
      width_q <= byte_width;
      remain  <= byte_width;
    end else if (pop) begin
      remain  <= remain - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      done            <= 1'b0;
      message_failure <= 1'b0;
      timer_start     <= 1'b0;
      timer_reset     <= 1'b1;
    end else begin
      state           <= state_d;
      done            <= done_d;
      message_failure <= fail_d;
      timer_start     <= tstart_d;
      timer_reset     <= tstart_d;
    end
  end

  // Missed ack beats everything; otherwise a met condition beats a same-cycle timeout.
  always_comb begin
    state_d = state;
    done_d  = 1'b0;
    fail_d  = 1'b0;
    if ((state != S_IDLE) && i2c_missed_ack) begin
      fail_d = 1'b1;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          if ((AW+1)'(byte_width) > count) fail_d = 1'b1;
          else state_d = S_BUS;
        end
        S_BUS:
          if (!i2c_bus_busy && !i2c_bus_active) state_d = S_CMD;
          else if (timer_exp) fail_d = 1'b1;
        S_CMD:
          if (i2c_cmd_ready) state_d = S_REG;
          else if (timer_exp) fail_d = 1'b1;
        S_REG:
          if (i2c_data_out_ready) state_d = (width_q == 4'd0) ? S_FREE : S_DATA;
          else if (timer_exp) fail_d = 1'b1;
        S_DATA:
          if (i2c_data_out_ready) begin
            if (remain == 4'd1) state_d = S_FREE;
          end else if (timer_exp) fail_d = 1'b1;
        S_FREE:
          if (!i2c_bus_busy && !i2c_bus_control) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else if (timer_exp) fail_d = 1'b1;
        default: state_d = S_IDLE;
      endcase
    end
    if (fail_d) state_d = S_IDLE;
  end

  always_comb begin
    busy                   = (state != S_IDLE);
    i2c_cmd_valid          = (state == S_CMD);
    i2c_cmd_start          = (state == S_CMD);
    i2c_cmd_write_multiple = (state == S_CMD);
    i2c_cmd_stop           = (state == S_CMD);
    i2c_data_out_valid     = (state == S_REG) || (state == S_DATA);
    i2c_data_out           = 8'h00;
    i2c_data_out_last      = 1'b0;
    if (state == S_REG) begin
      i2c_data_out      = reg_q;
      i2c_data_out_last = (width_q == 4'd0);
    end else if (state == S_DATA) begin
      i2c_data_out      = mem[rd_ptr];
      i2c_data_out_last = (remain == 4'd1);
    end
  end

  assign i2c_dev_address = dev_q;
  assign i2c_cmd_read    = 1'b0;
  assign timer_param     = 4'(TIMEOUT_MS);

endmodule

// File: tb/tb_i2c_write_reg.sv
// Bench for i2c_write_reg: table vectors, hand-written abort/stall/reset sequences
// and randomized transactions checked against a queue-based model of the writer.
module tb_i2c_write_reg;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] dev_address;
  logic [7:0] reg_address;
  logic [3:0] byte_width;
  logic       start;
  logic [7:0] load_data;
  logic       load_en;
  logic       load_full;
  logic [4:0] load_count;
  logic       busy, done, message_failure;
  logic       timer_exp, timer_start, timer_reset;
  logic [3:0] timer_param;
  logic       i2c_cmd_ready = 1'b0;
  logic       i2c_bus_busy, i2c_bus_control, i2c_bus_active, i2c_missed_ack;
  logic [6:0] i2c_dev_address;
  logic       i2c_cmd_start, i2c_cmd_read, i2c_cmd_write_multiple, i2c_cmd_stop, i2c_cmd_valid;
  logic [7:0] i2c_data_out;
  logic       i2c_data_out_valid, i2c_data_out_last;
  logic       i2c_data_out_ready = 1'b0;

  i2c_write_reg #(.DEPTH(DEPTH), .TIMEOUT_MS(1)) dut (
    .clk(clk), .reset(reset), .dev_address(dev_address), .reg_address(reg_address),
    .byte_width(byte_width), .start(start), .load_data(load_data), .load_en(load_en),
    .load_full(load_full), .load_count(load_count), .busy(busy), .done(done),
    .message_failure(message_failure), .timer_exp(timer_exp), .timer_start(timer_start),
    .timer_reset(timer_reset), .timer_param(timer_param), .i2c_cmd_ready(i2c_cmd_ready),
    .i2c_bus_busy(i2c_bus_busy), .i2c_bus_control(i2c_bus_control),
    .i2c_bus_active(i2c_bus_active), .i2c_missed_ack(i2c_missed_ack),
    .i2c_dev_address(i2c_dev_address), .i2c_cmd_start(i2c_cmd_start),
    .i2c_cmd_read(i2c_cmd_read), .i2c_cmd_write_multiple(i2c_cmd_write_multiple),
    .i2c_cmd_stop(i2c_cmd_stop), .i2c_cmd_valid(i2c_cmd_valid), .i2c_data_out(i2c_data_out),
    .i2c_data_out_valid(i2c_data_out_valid), .i2c_data_out_last(i2c_data_out_last),
    .i2c_data_out_ready(i2c_data_out_ready)
  );

  always #5 clk = ~clk;

  int nchk = 0, nfail = 0;
  logic [7:0] ld_q[$], mq[$], got_data[$];
  bit         got_last[$];
  int cmd_cnt = 0, cmdv_cnt = 0, cmd_bad = 0, done_cnt = 0, fail_cnt = 0, ts_cnt = 0;
  int stab_obs = 0, stab_err = 0;
  logic [6:0] cmd_addr = '0;
  bit   rdy_rand = 1'b0;
  int   stall_at = -1, stall_base = 0;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Master-side responder: ready either always high or random, with an optional
  // 5-cycle hold-off when the stream reaches byte index stall_at.
  always @(posedge clk) begin : rdy_drv
    static int stall_cyc = 0;
    #1;
    if (rdy_rand) begin
      i2c_cmd_ready      = 1'($urandom_range(0, 1));
      i2c_data_out_ready = ($urandom_range(0, 2) != 0);
    end else begin
      i2c_cmd_ready      = 1'b1;
      i2c_data_out_ready = 1'b1;
    end
    if (stall_at >= 0 && i2c_data_out_valid && (got_data.size() - stall_base == stall_at)
        && stall_cyc < 5) begin
      i2c_data_out_ready = 1'b0;
      stall_cyc++;
    end else if (got_data.size() - stall_base != stall_at) begin
      stall_cyc = 0;
    end
  end

  // Passive monitor, sampled mid-cycle.
  always @(negedge clk) begin : mon
    static bit pv = 1'b0;
    static logic [7:0] pd = '0;
    static logic pl = 1'b0;
    if (reset) begin
      pv = 1'b0;
    end else begin
      if (i2c_cmd_valid) cmdv_cnt++;
      if (i2c_cmd_valid && i2c_cmd_ready) begin
        cmd_cnt++;
        cmd_addr = i2c_dev_address;
        if (!(i2c_cmd_start && i2c_cmd_write_multiple && i2c_cmd_stop && !i2c_cmd_read)) cmd_bad++;
      end
      if (i2c_data_out_valid && i2c_data_out_ready) begin
        got_data.push_back(i2c_data_out);
        got_last.push_back(i2c_data_out_last);
      end
      if (done) done_cnt++;
      if (message_failure) fail_cnt++;
      if (timer_start) ts_cnt++;
      if (pv) begin
        stab_obs++;
        if (!i2c_data_out_valid || i2c_data_out !== pd || i2c_data_out_last !== pl) stab_err++;
      end
      pv = i2c_data_out_valid && !i2c_data_out_ready;
      pd = i2c_data_out;
      pl = i2c_data_out_last;
    end
  end

  task automatic load_bytes();
    foreach (ld_q[i]) begin
      load_data = ld_q[i];
      load_en = 1'b1;
      tick();
      if (mq.size() < DEPTH) mq.push_back(ld_q[i]);
    end
    load_en = 1'b0;
    tick();
    chk("load_count", int'(load_count), mq.size());
    chk("load_full", int'(load_full), int'(mq.size() == DEPTH));
  endtask

  // kind: -1 = outcome from model, 0/1 = table-stated outcome; ack_at >= 0 injects
  // a missed ack while stream byte ack_at is on the bus.
  task automatic run_txn(input logic [3:0] w, input logic [7:0] rg, input logic [6:0] dv,
                         input int kind, input int ack_at);
    int d0, f0, c0, cv0, t0, b0, bad0, nexp;
    bit mok, ok, acked, fin;
    logic [7:0] exp_q[$];
    load_bytes();
    mok = (int'(w) <= mq.size());
    exp_q = {rg};
    if (mok) for (int i = 0; i < int'(w); i++) exp_q.push_back(mq[i]);
    d0 = done_cnt; f0 = fail_cnt; c0 = cmd_cnt; cv0 = cmdv_cnt; t0 = ts_cnt; bad0 = cmd_bad;
    b0 = got_data.size();
    stall_base = b0;
    dev_address = dv; reg_address = rg; byte_width = w; start = 1'b1;
    tick();
    start = 1'b0;
    dev_address = ~dv; reg_address = ~rg; byte_width = ~w;
    if (!mok) chk("start_fail_1cyc", int'(message_failure), 1);
    acked = 1'b0;
    fin = 1'b0;
    for (int t = 0; t < 3000 && !fin; t++) begin
      if (done_cnt != d0 || fail_cnt != f0) begin
        fin = 1'b1;
      end else begin
        if (ack_at >= 0 && !acked && (got_data.size() - b0 == ack_at) && i2c_data_out_valid) begin
          i2c_missed_ack = 1'b1;
          tick();
          i2c_missed_ack = 1'b0;
          acked = 1'b1;
          chk("ack_valid_drop", int'(i2c_data_out_valid), 0);
          chk("ack_fail_pulse", int'(message_failure), 1);
          chk("ack_idle", int'(busy), 0);
          chk("ack_flush", int'(load_count), 0);
        end
        tick();
      end
    end
    chk("txn_finished", int'(fin), 1);
    tick(); tick();
    ok = mok && !acked;
    if (kind >= 0 && !acked) ok = (kind != 0);
    chk("done_pulses", done_cnt - d0, int'(ok));
    chk("fail_pulses", fail_cnt - f0, int'(!ok));
    chk("cmd_handshakes", cmd_cnt - c0, int'(mok));
    if (!mok) chk("no_cmd_valid", cmdv_cnt - cv0, 0);
    if (mok) chk("cmd_addr", int'(cmd_addr), int'(dv));
    chk("cmd_fields", cmd_bad - bad0, 0);
    nexp = acked ? ack_at : (mok ? exp_q.size() : 0);
    chk("byte_count", got_data.size() - b0, nexp);
    for (int i = 0; i < nexp && b0 + i < got_data.size(); i++) begin
      chk("data_byte", int'(got_data[b0+i]), int'(exp_q[i]));
      chk("data_last", int'(got_last[b0+i]), int'(!acked && i == nexp - 1));
    end
    if (!acked) chk("timer_starts", ts_cnt - t0, mok ? (w != 0 ? 5 : 4) : 0);
    chk("end_count", int'(load_count), 0);
    chk("end_busy", int'(busy), 0);
    mq.delete();
  endtask

  typedef struct {
    int              n;
    logic [3:0][7:0] d;
    logic [3:0]      w;
    logic [7:0]      rg;
    logic [6:0]      dv;
    bit              texp;
    int              exp_ok;
  } vec_t;
  vec_t tbl[5];

  initial begin
    int t0, cv0, f0, b0, s0, o0, n;
    reset = 1'b1; start = 1'b0; load_en = 1'b0; load_data = '0;
    dev_address = '0; reg_address = '0; byte_width = '0; timer_exp = 1'b0;
    i2c_bus_busy = 1'b0; i2c_bus_control = 1'b0; i2c_bus_active = 1'b0; i2c_missed_ack = 1'b0;

    tbl[0] = '{3, 32'h00C3B2A1, 4'd3, 8'h8A, 7'h29, 1'b0, 1};
    tbl[1] = '{0, 32'h00000000, 4'd0, 8'h01, 7'h10, 1'b0, 1};
    tbl[2] = '{2, 32'h00002211, 4'd3, 8'h40, 7'h20, 1'b0, 0};
    tbl[3] = '{4, 32'h04030201, 4'd2, 8'h55, 7'h33, 1'b0, 1};
    tbl[4] = '{4, 32'hD4D3D2D1, 4'd4, 8'h66, 7'h7F, 1'b1, 1};

    #1;
    chk("rst_timer_reset", int'(timer_reset), 1);
    chk("rst_timer_param", int'(timer_param), 1);
    chk("rst_outs_zero", int'({busy, done, message_failure, timer_start, i2c_cmd_valid,
        i2c_data_out_valid, i2c_data_out_last, load_full, load_count, i2c_dev_address}), 0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // Table vectors (texp holds timer_exp high: met conditions must still win).
    foreach (tbl[k]) begin
      ld_q = {};
      for (int i = 0; i < tbl[k].n; i++) ld_q.push_back(tbl[k].d[i]);
      timer_exp = tbl[k].texp;
      run_txn(tbl[k].w, tbl[k].rg, tbl[k].dv, tbl[k].exp_ok, -1);
      timer_exp = 1'b0;
    end

    // Overfill: 17 pushes, 16 kept; write 15 of them.
    ld_q = {};
    for (int i = 0; i < 17; i++) ld_q.push_back(8'(8'h30 + i));
    run_txn(4'd15, 8'hF0, 7'h0F, 1, -1);

    // Back-pressure on the 2nd data byte.
    s0 = stab_err; o0 = stab_obs;
    ld_q = {8'h10, 8'h20, 8'h30, 8'h40};
    stall_at = 2;
    run_txn(4'd4, 8'hA5, 7'h2A, 1, -1);
    chk("stall_observed", int'(stab_obs - o0 >= 5), 1);
    chk("stall_stable", stab_err - s0, 0);

    // Missed ack during the 2nd data byte.
    ld_q = {8'h11, 8'h22, 8'h33, 8'h44};
    run_txn(4'd4, 8'h5C, 7'h31, -1, 2);
    stall_at = -1;

    // Bus stays busy until the timer expires.
    i2c_bus_busy = 1'b1;
    t0 = ts_cnt; cv0 = cmdv_cnt; f0 = fail_cnt;
    dev_address = 7'h12; reg_address = 8'h34; byte_width = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("to_busy", int'(busy), 1);
    load_data = 8'h77; load_en = 1'b1;
    tick();
    load_en = 1'b0;
    chk("load_ignored_busy", int'(load_count), 0);
    repeat (98) tick();
    chk("to_waiting", int'(busy), 1);
    chk("to_no_cmd", cmdv_cnt - cv0, 0);
    chk("to_one_timer_start", ts_cnt - t0, 1);
    timer_exp = 1'b1;
    tick();
    timer_exp = 1'b0;
    chk("to_fail_pulse", int'(message_failure), 1);
    chk("to_idle", int'(busy), 0);
    chk("to_cmd_low", int'(i2c_cmd_valid), 0);
    tick();
    chk("to_fail_once", fail_cnt - f0, 1);
    i2c_bus_busy = 1'b0;

    // Randomized transactions with random master back-pressure.
    rdy_rand = 1'b1;
    s0 = stab_err;
    for (int k = 0; k < 30; k++) begin
      ld_q = {};
      n = $urandom_range(0, 18);
      repeat (n) ld_q.push_back(8'($urandom));
      run_txn(4'($urandom_range(0, 15)), 8'($urandom), 7'($urandom), -1, -1);
    end
    rdy_rand = 1'b0;
    chk("rand_stability", stab_err - s0, 0);

    // Asynchronous reset in the middle of the data phase.
    ld_q = {8'h5A, 8'h6B, 8'h7C, 8'h8D};
    stall_at = 2;
    load_bytes();
    b0 = got_data.size();
    stall_base = b0;
    dev_address = 7'h44; reg_address = 8'h99; byte_width = 4'd4; start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 0; t < 200 && !((got_data.size() - b0 == 2) && i2c_data_out_valid); t++) tick();
    chk("ar_in_data", int'(i2c_data_out_valid && (got_data.size() - b0 == 2)), 1);
    #2 reset = 1'b1;
    #1;
    chk("ar_timer_reset", int'(timer_reset), 1);
    chk("ar_timer_param", int'(timer_param), 1);
    chk("ar_outs_zero", int'({busy, done, message_failure, timer_start, i2c_cmd_valid,
        i2c_data_out_valid, i2c_data_out_last, i2c_data_out, load_count, i2c_dev_address}), 0);
    tick();
    reset = 1'b0;
    stall_at = -1;
    mq.delete();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
